// File: rtl/store_buffer_pkg.sv
// Shared store buffer definitions: default geometry and the layout of a packed entry.
// Packed entry layout, MSB to LSB: {word address, data, byte enable}.
package store_buffer_pkg;

    localparam int SB_DEPTH      = 4;
    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;

    function automatic int sb_be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int sb_waddr_width(input int addr_w);
        return addr_w - 2;
    endfunction

    function automatic int sb_be_lsb();
        return 0;
    endfunction

    function automatic int sb_data_lsb(input int data_w);
        return sb_be_lsb() + sb_be_width(data_w);
    endfunction

    function automatic int sb_addr_lsb(input int data_w);
        return sb_data_lsb(data_w) + data_w;
    endfunction

    function automatic int sb_entry_width(input int addr_w, input int data_w);
        return sb_addr_lsb(data_w) + sb_waddr_width(addr_w);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares a load word address against every store buffer entry.
// Reports all hits and the index of the youngest hit, searched backward from tail-1 with wrap.
module sb_match #(
    parameter int DEPTH       = 4,
    parameter int WADDR_WIDTH = 30,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH*WADDR_WIDTH-1:0] entry_waddr,
    input  logic [WADDR_WIDTH-1:0]       rd_waddr,
    input  logic [PTR_W-1:0]             tail,
    output logic [DEPTH-1:0]             hit,
    output logic [PTR_W-1:0]             youngest
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (entry_waddr[i*WADDR_WIDTH +: WADDR_WIDTH] == rd_waddr);
        end
    end

    // Walk oldest-to-youngest so the last assignment is the entry closest to tail-1.
    always_comb begin
        youngest = '0;
        idx      = '0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (hit[idx]) begin
                youngest = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the CPU store port and the data_mem write port.
// Optional store-to-load forwarding of full-word matches: define STORE_BUFFER_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = SB_DEPTH,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0]   cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wr_data,
    input  logic [DATA_WIDTH/8-1:0] cpu_wr_byte_enable,
    input  logic                    cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0]   cpu_rd_addr,
    input  logic                    flush_req,
    output logic                    buf_stall,
    output logic                    rd_conflict,
    output logic                    fwd_valid,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_byte_enable,
    output logic                    empty
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BE_W     = sb_be_width(DATA_WIDTH);
    localparam int WA_W     = sb_waddr_width(ADDR_WIDTH);
    localparam int ENTRY_W  = sb_entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int BE_LSB   = sb_be_lsb();
    localparam int DATA_LSB = sb_data_lsb(DATA_WIDTH);
    localparam int ADDR_LSB = sb_addr_lsb(DATA_WIDTH);

    logic [ENTRY_W-1:0]    entry_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic [DEPTH*WA_W-1:0] entry_waddr_flat;
    logic [DEPTH-1:0]      hit;
    logic [PTR_W-1:0]      youngest;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  full;
    logic                  enq;
    logic                  deq;
    logic                  unused_addr_bits;

    always_comb begin
        entry_waddr_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_waddr_flat[i*WA_W +: WA_W] = entry_q[i][ADDR_LSB +: WA_W];
        end
    end

    sb_match #(
        .DEPTH       (DEPTH),
        .WADDR_WIDTH (WA_W)
    ) u_match (
        .valid       (valid_q),
        .entry_waddr (entry_waddr_flat),
        .rd_waddr    (cpu_rd_addr[ADDR_WIDTH-1:2]),
        .tail        (tail_q),
        .hit         (hit),
        .youngest    (youngest)
    );

`ifdef STORE_BUFFER_FWD_EN
    logic [ENTRY_W-1:0] young_entry;

    always_comb begin
        young_entry = entry_q[youngest];
        fwd_valid   = rd_conflict && (&young_entry[BE_LSB +: BE_W]);
        fwd_data    = fwd_valid ? young_entry[DATA_LSB +: DATA_WIDTH] : '0;
    end

    always_comb unused_addr_bits = ^{cpu_rd_addr[1:0], cpu_wr_addr[1:0]};
`else
    always_comb begin
        fwd_valid = 1'b0;
        fwd_data  = '0;
    end

    always_comb unused_addr_bits = ^{cpu_rd_addr[1:0], cpu_wr_addr[1:0], youngest};
`endif

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        rd_conflict = cpu_rd_en && (|hit);
        // A conflicting load yields the port so the store it waits on can drain.
        mem_wr_en   = !empty && (!cpu_rd_en || rd_conflict);
        enq         = cpu_wr_en && !full;
        deq         = mem_wr_en;
        buf_stall   = (cpu_wr_en && full) || (rd_conflict && !fwd_valid) || (flush_req && !empty);
    end

    always_comb begin
        head_entry         = entry_q[head_q];
        mem_wr_addr        = '0;
        mem_wr_data        = '0;
        mem_wr_byte_enable = '0;
        if (!empty) begin
            mem_wr_addr        = {head_entry[ADDR_LSB +: WA_W], 2'b00};
            mem_wr_data        = head_entry[DATA_LSB +: DATA_WIDTH];
            mem_wr_byte_enable = head_entry[BE_LSB +: BE_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                entry_q[tail_q] <= {cpu_wr_addr[ADDR_WIDTH-1:2], cpu_wr_data, cpu_wr_byte_enable};
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table, directed corner sequences, random vs queue model.
// Expectations follow STORE_BUFFER_FWD_EN the same way the design does.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_en;
    logic [31:0] cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic [3:0]  cpu_wr_byte_enable;
    logic        cpu_rd_en;
    logic [31:0] cpu_rd_addr;
    logic        flush_req;
    logic        buf_stall;
    logic        rd_conflict;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_byte_enable;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic        obs_stall, obs_conf, obs_mwe, obs_empty, obs_fwd_valid;
    logic [31:0] obs_maddr, obs_mdata, obs_fwd_data;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;
    ent_t model_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic [31:0] ra;
        logic        exp_stall;
        logic        exp_conf;
        logic        exp_mwe;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mdata;
        logic        exp_empty;
    } vec_t;
    vec_t tbl[9];

    store_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_wr_en          (cpu_wr_en),
        .cpu_wr_addr        (cpu_wr_addr),
        .cpu_wr_data        (cpu_wr_data),
        .cpu_wr_byte_enable (cpu_wr_byte_enable),
        .cpu_rd_en          (cpu_rd_en),
        .cpu_rd_addr        (cpu_rd_addr),
        .flush_req          (flush_req),
        .buf_stall          (buf_stall),
        .rd_conflict        (rd_conflict),
        .fwd_valid          (fwd_valid),
        .fwd_data           (fwd_data),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_byte_enable (mem_wr_byte_enable),
        .empty              (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the queue model, commit the model at posedge.
    task automatic step(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic rd, input logic [31:0] ra,
                        input logic fl);
        bit          full, conf, fv, mwe, stall;
        int          y;
        logic [31:0] fd, ma, md;
        logic [3:0]  mbe;
        ent_t        e;
        @(negedge clk);
        cpu_wr_en          = wr;
        cpu_wr_addr        = wa;
        cpu_wr_data        = wd;
        cpu_wr_byte_enable = be;
        cpu_rd_en          = rd;
        cpu_rd_addr        = ra;
        flush_req          = fl;
        #2;
        full = (model_q.size() == DEPTH);
        conf = 1'b0;
        y    = -1;
        if (rd) begin
            foreach (model_q[i]) begin
                if (model_q[i].waddr == ra[31:2]) begin
                    conf = 1'b1;
                    y    = i;
                end
            end
        end
        fv = 1'b0;
        fd = '0;
`ifdef STORE_BUFFER_FWD_EN
        if (conf && model_q[y].be == 4'hF) begin
            fv = 1'b1;
            fd = model_q[y].data;
        end
`endif
        mwe = (model_q.size() > 0) && (!rd || conf);
        ma  = '0;
        md  = '0;
        mbe = '0;
        if (model_q.size() > 0) begin
            ma  = {model_q[0].waddr, 2'b00};
            md  = model_q[0].data;
            mbe = model_q[0].be;
        end
        stall = (wr && full) || (conf && !fv) || (fl && model_q.size() > 0);
        chk("buf_stall", buf_stall, stall);
        chk("rd_conflict", rd_conflict, conf);
        chk("fwd_valid", fwd_valid, fv);
        chk("fwd_data", fwd_data, fd);
        chk("mem_wr_en", mem_wr_en, mwe);
        chk("mem_wr_addr", mem_wr_addr, ma);
        chk("mem_wr_data", mem_wr_data, md);
        chk("mem_wr_be", mem_wr_byte_enable, mbe);
        chk("empty", empty, model_q.size() == 0);
        obs_stall     = buf_stall;
        obs_conf      = rd_conflict;
        obs_mwe       = mem_wr_en;
        obs_maddr     = mem_wr_addr;
        obs_mdata     = mem_wr_data;
        obs_empty     = empty;
        obs_fwd_valid = fwd_valid;
        obs_fwd_data  = fwd_data;
        @(posedge clk);
        if (mwe) void'(model_q.pop_front());
        if (wr && !full) begin
            e.waddr = wa[31:2];
            e.data  = wd;
            e.be    = be;
            model_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] ra, wa;
        logic [3:0]  be;

        rst = 1'b1;
        cpu_wr_en = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_byte_enable = '0;
        cpu_rd_en = 1'b0; cpu_rd_addr = '0; flush_req = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_stall", buf_stall, 1'b0);
        chk("rst_conflict", rd_conflict, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_fwd_data", fwd_data, 32'h0);
        chk("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_wr_addr, 32'h0);
        chk("rst_mem_data", mem_wr_data, 32'h0);
        chk("rst_mem_be", mem_wr_byte_enable, 4'h0);
        rst = 1'b0;

        // Vector table: four in-order stores drained, then a partial-lane load conflict.
        tbl[0] = '{1'b1, 32'h1000_0000, 32'hAAAA_0001, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1};
        tbl[1] = '{1'b1, 32'h1000_0004, 32'hAAAA_0002, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'hAAAA_0001, 1'b0};
        tbl[2] = '{1'b1, 32'h1000_0008, 32'hAAAA_0003, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1000_0004, 32'hAAAA_0002, 1'b0};
        tbl[3] = '{1'b1, 32'h1000_000C, 32'hAAAA_0004, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1000_0008, 32'hAAAA_0003, 1'b0};
        tbl[4] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1000_000C, 32'hAAAA_0004, 1'b0};
        tbl[5] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1};
        tbl[6] = '{1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'h3, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1};
        tbl[7] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h1000_0022, 1'b1, 1'b1, 1'b1, 32'h1000_0020, 32'hAABB_CCDD, 1'b0};
        tbl[8] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h1000_0022, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rd, tbl[i].ra, 1'b0);
            chk($sformatf("tbl%0d_stall", i), obs_stall, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_conflict", i), obs_conf, tbl[i].exp_conf);
            chk($sformatf("tbl%0d_mem_wr_en", i), obs_mwe, tbl[i].exp_mwe);
            chk($sformatf("tbl%0d_mem_addr", i), obs_maddr, tbl[i].exp_maddr);
            chk($sformatf("tbl%0d_mem_data", i), obs_mdata, tbl[i].exp_mdata);
            chk($sformatf("tbl%0d_empty", i), obs_empty, tbl[i].exp_empty);
        end

        // Fill while a non-matching load owns the port, then a fifth store must wait.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h1000_0200 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        step(1'b1, 32'h1000_0210, 32'hBEEF_0005, 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        chk("full_stall", obs_stall, 1'b1);
        chk("full_no_drain", obs_mwe, 1'b0);
        step(1'b1, 32'h1000_0210, 32'hBEEF_0005, 4'hF, 1'b0, 32'h0, 1'b0);
        chk("full_drop_rd_stall", obs_stall, 1'b1);
        chk("full_drop_rd_addr", obs_maddr, 32'h1000_0200);
        step(1'b1, 32'h1000_0210, 32'hBEEF_0005, 4'hF, 1'b0, 32'h0, 1'b0);
        chk("free_slot_accept", obs_stall, 1'b0);
        repeat (5) idle();
        chk("wrap_drained", obs_empty, 1'b1);

        // Two full-word stores to one word, then a load of that word.
        step(1'b1, 32'h1000_0040, 32'h1111_1111, 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        step(1'b1, 32'h1000_0040, 32'h2222_2222, 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000_0040, 1'b0);
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd_hit_valid", obs_fwd_valid, 1'b1);
        chk("fwd_hit_data", obs_fwd_data, 32'h2222_2222);
        chk("fwd_hit_stall", obs_stall, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000_0040, 1'b0);
        idle();
`else
        n = obs_stall ? 1 : 0;
        for (int c = 0; c < 8 && obs_stall; c++) begin
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000_0040, 1'b0);
            if (obs_stall) n++;
        end
        chk("nofwd_stall_cycles", n, 2);
        chk("nofwd_fwd_valid", obs_fwd_valid, 1'b0);
`endif

        // Flush with three queued entries.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h1000_0300 + 32'(4*i), 32'hC000_0000 + 32'(i), 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
            if (!obs_stall) break;
            n++;
        end
        chk("flush_stall_cycles", n, 3);
        chk("flush_empty", obs_empty, 1'b1);

        // Reset in the middle of a drain with three pending entries.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h1000_0400 + 32'(4*i), 32'hD000_0000 + 32'(i), 4'hF, 1'b1, 32'h1000_0100, 1'b0);
        @(negedge clk);
        cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; flush_req = 1'b0;
        #2;
        chk("pre_reset_drain", mem_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("mid_rst_mem_addr", mem_wr_addr, 32'h0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) idle();

        // Random traffic over a small word set so conflicts and forwarding occur often.
        for (int i = 0; i < 400; i++) begin
            wa = 32'h1000_0000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            ra = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            step(1'($urandom_range(0, 1)), wa, $urandom, be,
                 1'($urandom_range(0, 2) == 0), ra, 1'($urandom_range(0, 9) == 0));
        end
        repeat (6) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
